// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (sync, 16-bit length, big-endian
// words, XOR checksum) and writes the words into program memory from
// address 0 upward. The CPU is held in reset until a frame verifies.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        prog_mem_we,
  output logic [15:0] prog_mem_addr,
  output logic [15:0] prog_mem_wdata,
  output logic        cpu_hold,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_error
);

  // The gap counter only has to reach TIMEOUT_CYCLES-1 before firing.
  localparam int              GAP_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [7:0]       r_len_hi;
  logic [15:0]      r_len;
  logic [7:0]       r_hi;
  logic [7:0]       r_chk;
  logic [15:0]      r_cnt;
  logic [GAP_W-1:0] r_gap;

  logic             r_we;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic             r_hold;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_in_frame;
  logic             w_next_in_frame;
  logic             w_start;
  logic             w_word;
  logic             w_good;
  logic             w_bad;
  logic             w_timeout;
  logic             w_chk_ok;
  logic [15:0]      w_cnt_inc;
  logic [15:0]      w_len;

  assign w_in_frame      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_next_in_frame = (w_next  != S_IDLE) && (w_next  != S_DONE) && (w_next  != S_ERROR);
  assign w_start         = rx_valid && (rx_data == SYNC_BYTE) && !w_in_frame;
  assign w_word          = rx_valid && (r_state == S_DATA_LO);
  assign w_chk_ok        = (rx_data == r_chk);
  assign w_good          = rx_valid && (r_state == S_CHECK) && w_chk_ok;
  assign w_timeout       = (TIMEOUT_CYCLES != 0) && w_in_frame && !rx_valid && (r_gap == GAP_LAST);
  assign w_bad           = (rx_valid && (r_state == S_CHECK) && !w_chk_ok) || w_timeout;
  assign w_cnt_inc       = r_cnt + 16'd1;
  assign w_len           = {r_len_hi, rx_data};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode: one accepted byte per transition, timeout overrides.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_start) w_next = S_LEN_HI;
      S_LEN_HI:  if (rx_valid) w_next = S_LEN_LO;
      S_LEN_LO:  if (rx_valid) w_next = (w_len == 16'd0) ? S_CHECK : S_DATA_HI;
      S_DATA_HI: if (rx_valid) w_next = S_DATA_LO;
      S_DATA_LO: if (rx_valid) w_next = (w_cnt_inc == r_len) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (rx_valid) w_next = w_chk_ok ? S_DONE : S_ERROR;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_ERROR;
  end

  // Frame datapath: length, pending high byte and running checksum.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_chk <= 8'h00;
    end else if (rx_valid && w_in_frame && (r_state != S_CHECK)) begin
      r_chk <= r_chk ^ rx_data;
    end
    if (rx_valid && (r_state == S_LEN_HI))  r_len_hi <= rx_data;
    if (rx_valid && (r_state == S_LEN_LO))  r_len    <= w_len;
    if (rx_valid && (r_state == S_DATA_HI)) r_hi     <= rx_data;
  end

  // Idle-gap counter; restarts on every accepted byte and outside a frame.
  always_ff @(posedge clk) begin
    if (reset || rx_valid || !w_in_frame) r_gap <= '0;
    else                                  r_gap <= r_gap + 1'b1;
  end

  // Write port, word counter and status flags; reset kills a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
      r_cnt   <= 16'd0;
      r_hold  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= w_word;
      r_busy <= w_next_in_frame;
      if (w_word) begin
        r_addr  <= r_cnt;
        r_wdata <= {r_hi, rx_data};
      end
      if (w_start)     r_cnt <= 16'd0;
      else if (w_word) r_cnt <= w_cnt_inc;
      if (w_start) begin
        r_hold <= 1'b1;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_good) begin
          r_hold <= 1'b0;
          r_done <= 1'b1;
        end
        if (w_bad) r_err <= 1'b1;
      end
    end
  end

  assign prog_mem_we    = r_we;
  assign prog_mem_addr  = r_addr;
  assign prog_mem_wdata = r_wdata;
  assign cpu_hold       = r_hold;
  assign load_busy      = r_busy;
  assign load_done      = r_done;
  assign load_error     = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus randomized frames checked
// against a frame-level reference model (expected writes and final flags).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        prog_mem_we;
  logic [15:0] prog_mem_addr;
  logic [15:0] prog_mem_wdata;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_error;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  frame_q[$];

  prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .prog_mem_we(prog_mem_we), .prog_mem_addr(prog_mem_addr),
    .prog_mem_wdata(prog_mem_wdata), .cpu_hold(cpu_hold),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (prog_mem_we === 1'b1) wr_q.push_back({prog_mem_addr, prog_mem_wdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(2);
    reset = 1'b0;
  endtask

  // Reference checksum: XOR of every byte after the sync byte.
  function automatic logic [7:0] frame_xor(input logic [7:0] bytes[$]);
    logic [7:0] x = 8'h00;
    for (int i = 1; i < bytes.size(); i++) x ^= bytes[i];
    return x;
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++; if (cpu_hold !== 1'b1)        begin n_miss++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
    n_vec++; if (prog_mem_we !== 1'b0)     begin n_miss++; $display("FAIL rst_we: got %b want 0", prog_mem_we); end
    n_vec++; if (prog_mem_addr !== 16'd0)  begin n_miss++; $display("FAIL rst_addr: got %h want 0", prog_mem_addr); end
    n_vec++; if (prog_mem_wdata !== 16'd0) begin n_miss++; $display("FAIL rst_wdata: got %h want 0", prog_mem_wdata); end
    n_vec++; if ({load_busy, load_done, load_error} !== 3'b000)
      begin n_miss++; $display("FAIL rst_flags: got %b want 000", {load_busy, load_done, load_error}); end
  endtask

  task automatic test_good_frame();
    wr_q.delete();
    send_byte(8'hA5);
    n_vec++; if ({load_busy, cpu_hold} !== 2'b11) begin n_miss++; $display("FAIL good_busy_start: got %b want 11", {load_busy, cpu_hold}); end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    n_vec++; if ({prog_mem_we, prog_mem_addr, prog_mem_wdata} !== {1'b1, 16'd0, 16'h1234})
      begin n_miss++; $display("FAIL good_wr0: got %b/%h/%h want 1/0000/1234", prog_mem_we, prog_mem_addr, prog_mem_wdata); end
    send_byte(8'hAB);
    n_vec++; if (prog_mem_we !== 1'b0) begin n_miss++; $display("FAIL good_we_pulse: got %b want 0", prog_mem_we); end
    send_byte(8'hCD);
    n_vec++; if ({prog_mem_we, prog_mem_addr, prog_mem_wdata} !== {1'b1, 16'd1, 16'hABCD})
      begin n_miss++; $display("FAIL good_wr1: got %b/%h/%h want 1/0001/abcd", prog_mem_we, prog_mem_addr, prog_mem_wdata); end
    n_vec++; if ({load_busy, cpu_hold, load_done} !== 3'b110) begin n_miss++; $display("FAIL good_mid: got %b want 110", {load_busy, cpu_hold, load_done}); end
    send_byte(8'h42);
    n_vec++; if ({load_done, cpu_hold, load_error, load_busy} !== 4'b1000)
      begin n_miss++; $display("FAIL good_end: done/hold/err/busy got %b want 1000", {load_done, cpu_hold, load_error, load_busy}); end
    n_vec++; if (wr_q.size() !== 2) begin n_miss++; $display("FAIL good_nwr: got %0d want 2", wr_q.size()); end
  endtask

  task automatic test_empty();
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    n_vec++; if ({load_done, cpu_hold, load_error} !== 3'b100)
      begin n_miss++; $display("FAIL empty_end: done/hold/err got %b want 100", {load_done, cpu_hold, load_error}); end
    idle(2);
    n_vec++; if (wr_q.size() !== 0) begin n_miss++; $display("FAIL empty_nwr: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_bad_checksum();
    wr_q.delete();
    send_byte(8'hA5);
    n_vec++; if (load_done !== 1'b0) begin n_miss++; $display("FAIL bad_done_clear: got %b want 0", load_done); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    n_vec++; if ({load_error, cpu_hold, load_done, load_busy} !== 4'b1100)
      begin n_miss++; $display("FAIL bad_end: err/hold/done/busy got %b want 1100", {load_error, cpu_hold, load_done, load_busy}); end
    n_vec++; if (wr_q.size() !== 1 || wr_q[0] !== {16'd0, 16'h1234})
      begin n_miss++; $display("FAIL bad_wr: got n=%0d first=%h want n=1 00001234", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx); end
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78};
    frame_q.push_back(frame_xor(frame_q));
    send_byte(frame_q[0]);
    n_vec++; if (load_error !== 1'b0) begin n_miss++; $display("FAIL recover_err_clear: got %b want 0", load_error); end
    for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i]);
    n_vec++; if ({load_done, load_error, cpu_hold} !== 3'b100)
      begin n_miss++; $display("FAIL recover_end: done/err/hold got %b want 100", {load_done, load_error, cpu_hold}); end
  endtask

  task automatic test_garbage();
    do_reset();
    wr_q.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    n_vec++; if ({load_busy, load_done, load_error, cpu_hold} !== 4'b0001)
      begin n_miss++; $display("FAIL garbage_idle: busy/done/err/hold got %b want 0001", {load_busy, load_done, load_error, cpu_hold}); end
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
    frame_q.push_back(frame_xor(frame_q));
    foreach (frame_q[i]) send_byte(frame_q[i]);
    n_vec++; if (wr_q.size() !== 1 || wr_q[0] !== {16'd0, 16'hA5A5})
      begin n_miss++; $display("FAIL inner_sync_wr: got n=%0d first=%h want n=1 0000a5a5", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx); end
    n_vec++; if ({load_done, load_error} !== 2'b10) begin n_miss++; $display("FAIL inner_sync_done: got %b want 10", {load_done, load_error}); end
  endtask

  task automatic test_timeout();
    int early = 0;
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    // Now one cycle after the 0x12 strobe; the error must appear 16 edges later.
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      if (load_error !== 1'b0) early++;
    end
    n_vec++; if (early != 0) begin n_miss++; $display("FAIL timeout_early: error seen in %0d cycles want 0", early); end
    @(posedge clk); #1;
    n_vec++; if ({load_error, cpu_hold, load_busy} !== 3'b110)
      begin n_miss++; $display("FAIL timeout_err: err/hold/busy got %b want 110", {load_error, cpu_hold, load_busy}); end
    n_vec++; if (wr_q.size() !== 0) begin n_miss++; $display("FAIL timeout_nwr: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h34;
    @(posedge clk); #1;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    n_vec++; if ({prog_mem_we, cpu_hold, load_busy, load_done, load_error} !== 5'b01000)
      begin n_miss++; $display("FAIL rstmid_state: we/hold/busy/done/err got %b want 01000", {prog_mem_we, cpu_hold, load_busy, load_done, load_error}); end
    send_byte(8'h56); send_byte(8'h78);
    idle(1);
    n_vec++; if (wr_q.size() !== 0) begin n_miss++; $display("FAIL rstmid_nwr: got %0d want 0", wr_q.size()); end
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
    frame_q.push_back(frame_xor(frame_q));
    foreach (frame_q[i]) send_byte(frame_q[i]);
    n_vec++; if (wr_q.size() !== 1 || wr_q[0] !== {16'd0, 16'hBEEF})
      begin n_miss++; $display("FAIL rstmid_reload: got n=%0d first=%h want n=1 0000beef", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx); end
    n_vec++; if ({load_done, cpu_hold} !== 2'b10) begin n_miss++; $display("FAIL rstmid_done: got %b want 10", {load_done, cpu_hold}); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 20; f++) begin
      int          n   = $urandom_range(0, 7);
      bit          bad = ($urandom_range(0, 3) == 0);
      int          gmax = (f < 10) ? 0 : 4;   // first half back to back
      logic [7:0]  b;
      logic [15:0] w;
      frame_q.delete(); exp_q.delete(); wr_q.delete();
      // Garbage between frames (never the sync byte) must be ignored.
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        send_byte(b);
      end
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
        w = ($urandom_range(0, 4) == 0) ? 16'hA5A5 : 16'($urandom);
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[7:0]);
        exp_q.push_back({16'(i), w});
      end
      b = frame_xor(frame_q);
      if (bad) b ^= 8'(1 << $urandom_range(0, 7));
      frame_q.push_back(b);
      foreach (frame_q[i]) begin
        send_byte(frame_q[i]);
        idle($urandom_range(0, gmax));
      end
      idle(1);
      n_vec++; if (wr_q.size() !== exp_q.size())
        begin n_miss++; $display("FAIL rnd%0d_nwr: got %0d want %0d", f, wr_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_vec++;
        if (i >= wr_q.size() || wr_q[i] !== exp_q[i])
          begin n_miss++; $display("FAIL rnd%0d_wr%0d: got %h want %h", f, i, (i < wr_q.size()) ? wr_q[i] : 32'hx, exp_q[i]); end
      end
      n_vec++; if ({load_done, load_error, cpu_hold, load_busy} !== {!bad, bad, bad, 1'b0})
        begin n_miss++; $display("FAIL rnd%0d_flags: done/err/hold/busy got %b want %b", f,
          {load_done, load_error, cpu_hold, load_busy}, {!bad, bad, bad, 1'b0}); end
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_good_frame();
    test_empty();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
